// File: rtl/result_reader_if.sv
// mem3 read port and reassembled-result stream seen by result_reader.
interface result_reader_if #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned RESULT_WIDTH = 18,
    parameter int unsigned COUNT_WIDTH  = 4
);
    logic                    mem_rd_en;
    logic [ADDR_WIDTH-1:0]   mem_rd_addr;
    logic [DATA_WIDTH-1:0]   mem_rd_data;
    logic                    res_valid;
    logic                    res_ready;
    logic [RESULT_WIDTH-1:0] res_data;
    logic [COUNT_WIDTH-1:0]  res_index;

    modport master (
        output mem_rd_en, mem_rd_addr, res_valid, res_data, res_index,
        input  mem_rd_data, res_ready
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr, res_valid, res_data, res_index,
        output mem_rd_data, res_ready
    );
endinterface

// File: rtl/result_reader.sv
// Drains multi-word results from mem3 and streams them out one result at a time.
// Optional running checksum of transferred results: define RESULT_READER_CHECKSUM_EN.
module result_reader #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned VECTOR_WIDTH = 4,
    parameter int unsigned RESULT_WIDTH = 2 * DATA_WIDTH + $clog2(VECTOR_WIDTH),
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned MEM_SIZE     = 16,
    parameter int unsigned COUNT_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [COUNT_WIDTH-1:0]  num_results,
    output logic                    busy,
    output logic                    done,
    output logic [RESULT_WIDTH-1:0] checksum,
    result_reader_if.master         bus
);
    localparam int unsigned BYTES  = (RESULT_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int unsigned WCNT_W = $clog2(BYTES + 1);

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, PRESENT, FINISH} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [COUNT_WIDTH-1:0]  remaining_q, remaining_d;
    logic [WCNT_W-1:0]       issued_q, issued_d;
    logic [WCNT_W-1:0]       slot_q, slot_d;
    logic                    rd_pend_q, rd_pend_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic                    valid_q, valid_d;
    logic [RESULT_WIDTH-1:0] data_q, data_d;
    logic [COUNT_WIDTH-1:0]  index_q, index_d;
    logic                    start_acc_c;
    logic                    xfer_c;

    function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == ADDR_WIDTH'(MEM_SIZE - 1)) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    assign start_acc_c = (state_q == IDLE) && start;
    assign xfer_c      = (state_q == PRESENT) && valid_q && bus.res_ready;

    // Word k of a result lands in bits [k*DATA_WIDTH +: DATA_WIDTH]; bits past RESULT_WIDTH fall away.
    always_comb begin
        data_d = data_q;
        for (int b = 0; b < int'(RESULT_WIDTH); b++) begin
            if (rd_pend_q && (slot_q == WCNT_W'(b / int'(DATA_WIDTH))))
                data_d[b] = bus.mem_rd_data[b % int'(DATA_WIDTH)];
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        issued_d    = issued_q;
        slot_d      = rd_pend_q ? slot_q + WCNT_W'(1) : slot_q;
        rd_pend_d   = rd_en_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd_en_d     = 1'b0;
        rd_addr_d   = '0;
        valid_d     = valid_q;
        index_d     = index_q;

        unique case (state_q)
            IDLE: begin
                if (start_acc_c) begin
                    busy_d      = 1'b1;
                    remaining_d = num_results;
                    index_d     = '0;
                    ptr_d       = base_addr;
                    if (num_results == '0) begin
                        state_d = FINISH;
                    end else begin
                        state_d   = FETCH;
                        rd_en_d   = 1'b1;
                        rd_addr_d = base_addr;
                        ptr_d     = wrap_inc(base_addr);
                        issued_d  = WCNT_W'(1);
                        slot_d    = '0;
                    end
                end
            end
            FETCH: begin
                if (issued_q < WCNT_W'(BYTES)) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = ptr_q;
                    ptr_d     = wrap_inc(ptr_q);
                    issued_d  = issued_q + WCNT_W'(1);
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d = PRESENT;
                valid_d = 1'b1;
            end
            PRESENT: begin
                if (xfer_c) begin
                    valid_d     = 1'b0;
                    remaining_d = remaining_q - COUNT_WIDTH'(1);
                    index_d     = index_q + COUNT_WIDTH'(1);
                    if (remaining_q > COUNT_WIDTH'(1)) begin
                        state_d   = FETCH;
                        rd_en_d   = 1'b1;
                        rd_addr_d = ptr_q;
                        ptr_d     = wrap_inc(ptr_q);
                        issued_d  = WCNT_W'(1);
                        slot_d    = '0;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            issued_q    <= '0;
            slot_q      <= '0;
            rd_pend_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            index_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            issued_q    <= issued_d;
            slot_q      <= slot_d;
            rd_pend_q   <= rd_pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            index_q     <= index_d;
        end
    end

`ifdef RESULT_READER_CHECKSUM_EN
    logic [RESULT_WIDTH-1:0] checksum_q, checksum_d;

    // Cleared on an accepted start, then held past done until the next one.
    always_comb begin
        checksum_d = checksum_q;
        if (start_acc_c)
            checksum_d = '0;
        else if (xfer_c)
            checksum_d = checksum_q + data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) checksum_q <= '0;
        else     checksum_q <= checksum_d;
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign busy            = busy_q;
    assign done            = done_q;
    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_rd_addr = rd_addr_q;
    assign bus.res_valid   = valid_q;
    assign bus.res_data    = data_q;
    assign bus.res_index   = index_q;
endmodule
